// File: rtl/jtsdram_bank_wr_if.sv
// Write-request bus between the bank filler (master) and the SDRAM controller (slave).
interface jtsdram_bank_wr_if #(
    parameter int unsigned AW = 22
) ();
    logic [AW-1:0] addr;
    logic          wr;
    logic [15:0]   wdata;
    logic          ack;
    logic          rdy;

    modport master (output addr, wr, wdata, input ack, rdy);
    modport slave  (input addr, wr, wdata, output ack, rdy);
endinterface

// File: rtl/jtsdram_bank_wr.sv
// SDRAM bank filler: writes one pattern word per address over the whole bank,
// with a per-state watchdog that aborts a stalled handshake.
module jtsdram_bank_wr #(
    parameter int unsigned AW      = 22,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [15:0]           data_ref,
    jtsdram_bank_wr_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   base_q, base_d;

    logic [15:0]   seed;
    logic [15:0]   lfsr_nxt;
    logic [AW-1:0] addr_inc;
    logic [TW-1:0] timer_inc;
    logic          timeout;

    // Word generator shared by the start path and the per-address advance
    function automatic logic [15:0] pattern(input logic [1:0] m, input logic [15:0] base,
                                            input logic [AW-1:0] a, input logic [15:0] l);
        logic [15:0] w;
        case (m)
            2'd0:    w = base;
            2'd1:    w = base ^ 16'(a);
            2'd2:    w = l;
            default: w = ~base;
        endcase
        return w;
    endfunction

    assign lfsr_nxt  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign addr_inc  = addr_q + AW'(1);
    assign timer_inc = timer_q + TW'(1);
    // The visit is aborted on the edge where the count would reach TIMEOUT
    assign timeout   = (timer_inc == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        timer_d = timer_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        base_d  = base_q;
        seed    = (data_ref == 16'h0000) ? 16'h0001 : data_ref;

        if (start) begin
            // Restart wins over any handshake seen in the same cycle
            mode_d  = mode;
            base_d  = data_ref;
            lfsr_d  = seed;
            addr_d  = '0;
            wr_d    = 1'b1;
            wdata_d = pattern(mode, data_ref, '0, seed);
            done_d  = 1'b0;
            err_d   = 1'b0;
            timer_d = '0;
            state_d = REQ;
        end else begin
            case (state_q)
                REQ: begin
                    if (bus.ack) begin
                        wr_d    = 1'b0;
                        timer_d = '0;
                        state_d = WAIT;
                    end else if (timeout) begin
                        wr_d    = 1'b0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                WAIT: begin
                    if (bus.rdy) begin
                        lfsr_d  = lfsr_nxt;
                        timer_d = '0;
                        if (addr_q == '1) begin
                            addr_d  = '0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_inc;
                            wdata_d = pattern(mode_q, base_q, addr_inc, lfsr_nxt);
                            wr_d    = 1'b1;
                            state_d = REQ;
                        end
                    end else if (timeout) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            lfsr_q  <= 16'h0001;
            mode_q  <= '0;
            base_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.wr    = wr_q;
    assign bus.wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q == REQ) || (state_q == WAIT);

endmodule

// File: tb/tb_jtsdram_bank_wr.sv
// Directed bench for jtsdram_bank_wr: table of full fills plus hand-written corner sequences.
module tb_jtsdram_bank_wr;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] data_ref;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    jtsdram_bank_wr_if #(.AW(2)) bus ();

    jtsdram_bank_wr #(.AW(2), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .data_ref (data_ref),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       mode;
        logic [15:0]      dref;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [1:0] m, input logic [15:0] d,
                                input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3);
        vec_t v;
        v.mode   = m;
        v.dref   = d;
        v.exp[0] = w0;
        v.exp[1] = w1;
        v.exp[2] = w2;
        v.exp[3] = w3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [15:0] d);
        mode     = m;
        data_ref = d;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic wait_wr(input string name);
        int n = 0;
        while (bus.wr !== 1'b1 && n < 12) begin
            cyc();
            n++;
        end
        chk($sformatf("%s wr_seen", name), {31'b0, bus.wr}, 32'd1);
    endtask

    // One write: ack one cycle after wr, optional rdy two cycles after ack
    task automatic write_cycle(input string name, input int idx, input logic [15:0] exp,
                               input bit give_rdy);
        wait_wr(name);
        chk($sformatf("%s addr%0d", name, idx), {30'b0, bus.addr}, 32'(idx));
        chk($sformatf("%s wdata%0d", name, idx), {16'b0, bus.wdata}, {16'b0, exp});
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        chk($sformatf("%s wr_drop%0d", name, idx), {31'b0, bus.wr}, 32'd0);
        cyc();
        if (give_rdy) begin
            bus.rdy = 1'b1;
            cyc();
            bus.rdy = 1'b0;
        end
    endtask

    initial begin
        int  n;
        bit  saw_wr;

        vecs[0] = mk(2'd0, 16'hA55A, 16'hA55A, 16'hA55A, 16'hA55A, 16'hA55A);
        vecs[1] = mk(2'd1, 16'h00F0, 16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3);
        vecs[2] = mk(2'd2, 16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008);
        vecs[3] = mk(2'd2, 16'h8000, 16'h8000, 16'h0001, 16'h0002, 16'h0004);
        vecs[4] = mk(2'd3, 16'h1234, 16'hEDCB, 16'hEDCB, 16'hEDCB, 16'hEDCB);
        vecs[5] = mk(2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC);

        rst = 1'b1; start = 1'b0; mode = '0; data_ref = '0;
        bus.ack = 1'b0; bus.rdy = 1'b0;
        cyc(2);
        chk("rst addr",  {30'b0, bus.addr},  32'd0);
        chk("rst wr",    {31'b0, bus.wr},    32'd0);
        chk("rst wdata", {16'b0, bus.wdata}, 32'd0);
        chk("rst done",  {31'b0, done},      32'd0);
        chk("rst err",   {31'b0, err},       32'd0);
        chk("rst busy",  {31'b0, busy},      32'd0);
        rst = 1'b0;
        cyc();

        // Handshake inputs are ignored while idle
        bus.ack = 1'b1; bus.rdy = 1'b1;
        cyc(2);
        bus.ack = 1'b0; bus.rdy = 1'b0;
        chk("idle busy", {31'b0, busy},    32'd0);
        chk("idle wr",   {31'b0, bus.wr},  32'd0);
        chk("idle addr", {30'b0, bus.addr}, 32'd0);

        foreach (vecs[v]) begin
            pulse_start(vecs[v].mode, vecs[v].dref);
            for (int i = 0; i < 4; i++)
                write_cycle($sformatf("vec%0d", v), i, vecs[v].exp[i], 1'b1);
            chk($sformatf("vec%0d done", v), {31'b0, done},     32'd1);
            chk($sformatf("vec%0d err", v),  {31'b0, err},      32'd0);
            chk($sformatf("vec%0d addr", v), {30'b0, bus.addr}, 32'd0);
            chk($sformatf("vec%0d wr", v),   {31'b0, bus.wr},   32'd0);
            chk($sformatf("vec%0d busy", v), {31'b0, busy},     32'd0);
        end

        // DONE holds through stray handshakes
        bus.ack = 1'b1; bus.rdy = 1'b1;
        cyc(3);
        bus.ack = 1'b0; bus.rdy = 1'b0;
        chk("done hold", {31'b0, done},   32'd1);
        chk("done wr",   {31'b0, bus.wr}, 32'd0);

        // Timeout in REQ: wr high for exactly TIMEOUT cycles
        pulse_start(2'd0, 16'h1111);
        n = 0;
        while (bus.wr === 1'b1 && n < 20) begin
            n++;
            cyc();
        end
        chk("to_req wr_cycles", 32'(n), 32'd8);
        chk("to_req err",  {31'b0, err},      32'd1);
        chk("to_req done", {31'b0, done},     32'd1);
        chk("to_req addr", {30'b0, bus.addr}, 32'd0);
        chk("to_req busy", {31'b0, busy},     32'd0);

        // Restart from DONE clears the sticky flags
        pulse_start(2'd0, 16'h2222);
        chk("restart done",  {31'b0, done},      32'd0);
        chk("restart err",   {31'b0, err},       32'd0);
        chk("restart wr",    {31'b0, bus.wr},    32'd1);
        chk("restart wdata", {16'b0, bus.wdata}, 32'h2222);

        // Timeout in WAIT keeps the failing address
        write_cycle("to_wait", 0, 16'h2222, 1'b1);
        write_cycle("to_wait", 1, 16'h2222, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            n++;
            cyc();
        end
        chk("to_wait err",  {31'b0, err},      32'd1);
        chk("to_wait done", {31'b0, done},     32'd1);
        chk("to_wait addr", {30'b0, bus.addr}, 32'd1);

        // Start while waiting at addr 2, coincident rdy discarded
        pulse_start(2'd1, 16'h0100);
        write_cycle("rs", 0, 16'h0100, 1'b1);
        write_cycle("rs", 1, 16'h0101, 1'b1);
        write_cycle("rs", 2, 16'h0102, 1'b0);
        chk("rs in_wait", {31'b0, busy}, 32'd1);
        mode = 2'd1; data_ref = 16'h0200;
        start = 1'b1; bus.rdy = 1'b1;
        cyc();
        start = 1'b0; bus.rdy = 1'b0;
        chk("rs addr",  {30'b0, bus.addr}, 32'd0);
        chk("rs wr",    {31'b0, bus.wr},   32'd1);
        chk("rs done",  {31'b0, done},     32'd0);
        chk("rs wdata", {16'b0, bus.wdata}, 32'h0200);
        cyc();
        chk("rs addr_hold", {30'b0, bus.addr}, 32'd0);
        chk("rs wr_hold",   {31'b0, bus.wr},   32'd1);

        // ack and rdy together in REQ: rdy ignored, addr unchanged
        bus.ack = 1'b1; bus.rdy = 1'b1;
        cyc();
        bus.ack = 1'b0; bus.rdy = 1'b0;
        chk("ackrdy wr",   {31'b0, bus.wr},   32'd0);
        chk("ackrdy addr", {30'b0, bus.addr}, 32'd0);
        chk("ackrdy busy", {31'b0, busy},     32'd1);
        cyc(2);
        chk("ackrdy wait_addr", {30'b0, bus.addr}, 32'd0);
        chk("ackrdy wait_wr",   {31'b0, bus.wr},   32'd0);
        bus.rdy = 1'b1;
        cyc();
        bus.rdy = 1'b0;
        chk("ackrdy next_addr",  {30'b0, bus.addr},  32'd1);
        chk("ackrdy next_wr",    {31'b0, bus.wr},    32'd1);
        chk("ackrdy next_wdata", {16'b0, bus.wdata}, 32'h0201);

        // Reset mid-fill dominates a coincident start
        rst = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("mrst addr",  {30'b0, bus.addr},  32'd0);
        chk("mrst wr",    {31'b0, bus.wr},    32'd0);
        chk("mrst wdata", {16'b0, bus.wdata}, 32'd0);
        chk("mrst done",  {31'b0, done},      32'd0);
        chk("mrst err",   {31'b0, err},       32'd0);
        chk("mrst busy",  {31'b0, busy},      32'd0);
        cyc();
        rst = 1'b0;
        saw_wr = 1'b0;
        bus.ack = 1'b1; bus.rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.wr === 1'b1) saw_wr = 1'b1;
        end
        bus.ack = 1'b0; bus.rdy = 1'b0;
        chk("mrst no_wr", {31'b0, saw_wr}, 32'd0);
        chk("mrst idle",  {31'b0, busy},   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
